// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared types and position-wrap helper for the step sequencer
//                and the mod-MOD up/down counter it drives.
//  Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam int DEFAULT_MOD = 5;
    localparam int POS_FN_W    = 16;

    // Next position of a 1..mod ring; holds the counter's own wrap rule.
    function automatic logic [POS_FN_W-1:0] pos_next_f(
        input logic [POS_FN_W-1:0] pos,
        input logic                up,
        input int                  mod
    );
        logic [POS_FN_W-1:0] r_mod;
        logic [POS_FN_W-1:0] w_res;
        r_mod = POS_FN_W'(mod);
        if (up) begin
            w_res = (pos >= r_mod) ? POS_FN_W'(1) : pos + POS_FN_W'(1);
        end else begin
            w_res = (pos <= POS_FN_W'(1)) ? r_mod : pos - POS_FN_W'(1);
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_pos_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : mod_pos_tracker
//  Description : Synchronous mod-MOD up/down position register, range 1..MOD.
//  Revision    : 1.0  initial release
// ============================================================================
module mod_pos_tracker
    import counter_pkg::*;
#(
    parameter int MOD = DEFAULT_MOD,
    parameter int W   = $clog2(MOD + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         up,
    output logic [W-1:0] pos
);

    logic [W-1:0] r_pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= W'(1);
        end else if (ena) begin
            r_pos <= W'(pos_next_f(POS_FN_W'(r_pos), up, MOD));
        end
    end

    assign pos = r_pos;

endmodule
`default_nettype wire

// File: rtl/counter_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : counter_step_sequencer
//  Description : Moore sequencer issuing spaced ena pulses to a mod-MOD
//                up/down counter, with shadow position, abort and done.
//  Revision    : 1.0  initial release
// ============================================================================
module counter_step_sequencer
    import counter_pkg::*;
#(
    parameter int MOD    = DEFAULT_MOD,
    parameter int STEP_W = 4,
    parameter int GAP    = 1,
    localparam int POS_W = $clog2(MOD + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_up,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    output logic              ena,
    output logic              up,
    output logic [POS_W-1:0]  pos,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int C_GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [STEP_W-1:0]   r_rem;
    logic [C_GAP_W-1:0]  r_gap;
    logic                r_dir;
    logic                r_aborted;
    logic                w_accept;
    logic                w_abort_end;

    assign w_accept = cmd_valid & cmd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_abort_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (cmd_steps == '0) ? ST_DONE : ST_STEP;
                end
            end
            ST_STEP: begin
                // Finishing the last step wins over a simultaneous abort.
                if (r_rem <= STEP_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end else if (abort) begin
                    w_state_nxt = ST_DONE;
                    w_abort_end = 1'b1;
                end else if (GAP > 0) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    w_state_nxt = ST_DONE;
                    w_abort_end = 1'b1;
                end else if (r_gap <= C_GAP_W'(1)) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_gap     <= '0;
            r_dir     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rem <= cmd_steps;
                        r_dir <= cmd_up;
                    end
                end
                ST_STEP: begin
                    if (r_rem != '0) begin
                        r_rem <= r_rem - STEP_W'(1);
                    end
                    r_gap <= C_GAP_W'(GAP);
                end
                ST_GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - C_GAP_W'(1);
                    end
                end
                default: begin
                end
            endcase
            if (w_state_nxt == ST_DONE) begin
                r_aborted <= w_abort_end;
            end
        end
    end

    // Ready is masked while rst is held so nothing is accepted during reset.
    assign cmd_ready = (r_state == ST_IDLE) & ~rst;
    assign ena       = (r_state == ST_STEP);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign aborted   = done & r_aborted;
    assign up        = busy & r_dir;

    mod_pos_tracker #(
        .MOD (MOD),
        .W   (POS_W)
    ) u_pos (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .up  (up),
        .pos (pos)
    );

endmodule
`default_nettype wire

// File: tb/tb_counter_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_step_sequencer
//  Description : Randomized self-checking bench with a move-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_step_sequencer;
    import counter_pkg::*;

    localparam int MOD    = 5;
    localparam int STEP_W = 4;
    localparam int GAP    = 1;
    localparam int POS_W  = $clog2(MOD + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_up;
    logic [STEP_W-1:0] cmd_steps;
    logic              abort;
    logic              ena;
    logic              up;
    logic [POS_W-1:0]  pos;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [POS_W-1:0]  cnt_pos;

    always #5 clk = ~clk;

    counter_step_sequencer #(
        .MOD    (MOD),
        .STEP_W (STEP_W),
        .GAP    (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_up    (cmd_up),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .ena       (ena),
        .up        (up),
        .pos       (pos),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    // The counter being sequenced, sharing rst with the sequencer.
    mod_pos_tracker #(
        .MOD (MOD),
        .W   (POS_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .up  (up),
        .pos (cnt_pos)
    );

    int   checks = 0;
    int   errors = 0;
    logic exp_valid = 1'b0;
    logic exp_ready, exp_ena, exp_up, exp_busy, exp_done, exp_ab;
    int   exp_pos;
    int   mpos;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("cmd_ready", int'(cmd_ready), int'(exp_ready));
            chk("ena", int'(ena), int'(exp_ena));
            chk("up", int'(up), int'(exp_up));
            chk("busy", int'(busy), int'(exp_busy));
            chk("done", int'(done), int'(exp_done));
            chk("aborted", int'(aborted), int'(exp_ab));
            chk("pos", int'(pos), exp_pos);
            chk("pos_vs_counter", int'(pos), int'(cnt_pos));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic r, input logic e, input logic u, input logic b,
                           input logic d, input logic a);
        exp_ready = r;
        exp_ena   = e;
        exp_up    = u;
        exp_busy  = b;
        exp_done  = d;
        exp_ab    = a;
        exp_pos   = mpos;
        exp_valid = 1'b1;
    endtask

    task automatic idle_cycle();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_up    = 1'($urandom);
        cmd_steps = STEP_W'($urandom);
        abort     = 1'($urandom);
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // Entered from an idle cycle; each reset cycle leaves everything at reset values.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst       = 1'b1;
            cmd_valid = 1'($urandom);
            cmd_up    = 1'($urandom);
            cmd_steps = STEP_W'($urandom);
            abort     = 1'($urandom);
            set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            mpos = 1;
        end
        rst = 1'b0;
    endtask

    // One move, cycle 0 = the accepting idle cycle. Pulses land at cycles
    // 1, 1+(GAP+1), ...; done follows the last pulse. Abort in cycle a ends the move
    // with done in a+1 unless a is the final pulse. rst_at asserts rst in that cycle.
    task automatic run_move(input logic d, input int n, input int a, input int rst_at,
                            input logic hold, input logic hd, input int hn);
        int dd;
        int last;
        logic ab;
        last = 1 + (n - 1) * (GAP + 1);
        dd   = (n == 0) ? 1 : last + 1;
        ab   = 1'b0;
        if (n > 0 && a >= 1 && a < dd && a != last) begin
            dd = a + 1;
            ab = 1'b1;
        end
        for (int c = 0; c <= dd; c++) begin
            rst = (c == rst_at);
            if (c == 0) begin
                cmd_valid = 1'b1;
                cmd_up    = d;
                cmd_steps = STEP_W'(n);
                abort     = 1'($urandom);
                set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                if (hold) begin
                    cmd_valid = 1'b1;
                    cmd_up    = hd;
                    cmd_steps = STEP_W'(hn);
                end else begin
                    cmd_valid = 1'($urandom);
                    cmd_up    = 1'($urandom);
                    cmd_steps = STEP_W'($urandom);
                end
                if (c < dd) begin
                    abort = (c == a);
                    set_exp(1'b0, ((c - 1) % (GAP + 1)) == 0, d, 1'b1, 1'b0, 1'b0);
                end else begin
                    abort = 1'($urandom);
                    set_exp(1'b0, 1'b0, d, 1'b1, 1'b1, ab);
                end
            end
            tick();
            if (c == rst_at) begin
                mpos = 1;
                break;
            end
            if (exp_ena) begin
                mpos = ((mpos - 1 + (d ? 1 : MOD - 1)) % MOD) + 1;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic d;
        logic hd;
        int   n;
        int   hn;
        int   a;
        int   ra;
        logic hold;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_up    = 1'b0;
        cmd_steps = '0;
        abort     = 1'b0;
        mpos      = 1;
        tick();
        do_reset(1);
        idle_cycle();

        // Up 3 from 1 -> 4.
        run_move(1'b1, 3, -1, -1, 1'b0, 1'b0, 0);
        chk("t2_pos_literal", int'(pos), 4);
        idle_cycle();
        do_reset(1);
        idle_cycle();

        // Down 2 from 1 -> 5 -> 4.
        run_move(1'b0, 2, -1, -1, 1'b0, 1'b0, 0);
        chk("t3_pos_literal", int'(pos), 4);

        // Zero-step move leaves pos alone.
        run_move(1'b1, 0, -1, -1, 1'b0, 1'b0, 0);
        chk("t4_pos_literal", int'(pos), 4);

        // Up 4 aborted in the first gap cycle -> one step only.
        run_move(1'b1, 4, 2, -1, 1'b0, 1'b0, 0);
        chk("t5_pos_literal", int'(pos), 5);

        // Reset in a STEP cycle with a command held behind it.
        run_move(1'b1, 5, -1, 3, 1'b1, 1'b1, 1);
        #1;
        chk("t6_pos_literal", int'(pos), 1);
        chk("t6_ready_literal", int'(cmd_ready), 1);
        run_move(1'b1, 1, -1, -1, 1'b0, 1'b0, 0);
        chk("t6_held_pos_literal", int'(pos), 2);

        hold = 1'b0;
        hd   = 1'b0;
        hn   = 0;
        for (int it = 0; it < 150; it++) begin
            if (hold) begin
                d = hd;
                n = hn;
            end else begin
                d = 1'($urandom);
                n = $urandom_range(0, 15);
            end
            a    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * n + 2) : -1;
            ra   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2 * n + 2) : -1;
            hold = 1'($urandom);
            hd   = 1'($urandom);
            hn   = $urandom_range(0, 15);
            run_move(d, n, a, ra, hold, hd, hn);
            if (!hold) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) begin
                    idle_cycle();
                end
            end
        end
        if (hold) begin
            run_move(hd, hn, -1, -1, 1'b0, 1'b0, 0);
        end
        idle_cycle();
        exp_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
